// File: rtl/window_conv3x3_if.sv
// Stream bundle between the window generator and the 3x3 convolution stage.
// master drives the taps and consumes the filtered pixels; slave is the filter.
`timescale 1ns/1ps
interface window_conv3x3_if #(
   parameter int CW = 8
);
   logic          in_valid;
   logic [7:0]    i11, i12, i13;
   logic [7:0]    i21, i22, i23;
   logic [7:0]    i31, i32, i33;
   logic [1:0]    mode;
   logic          out_valid;
   logic [7:0]    out_pixel;
   logic [CW-1:0] out_x;
   logic [CW-1:0] out_y;
   logic          frame_done;

   modport master (
      output in_valid, i11, i12, i13, i21, i22, i23, i31, i32, i33, mode,
      input  out_valid, out_pixel, out_x, out_y, frame_done
   );

   modport slave (
      input  in_valid, i11, i12, i13, i21, i22, i23, i31, i32, i33, mode,
      output out_valid, out_pixel, out_x, out_y, frame_done
   );
endinterface

// File: rtl/window_conv3x3.sv
// 3x3 kernel stage: gates border/start-up windows by raster position, then runs a
// 3-stage pipeline (register taps, kernel sum, normalise/saturate) toward the writer.
`timescale 1ns/1ps
module window_conv3x3 #(
   parameter int IMG_W = 100,
   parameter int IMG_H = 100,
   parameter int CW    = 8
) (
   input logic clk,
   input logic rst,
   window_conv3x3_if.slave bus
);

   function automatic logic signed [12:0] ext(input logic [7:0] v);
      return signed'({5'b0, v});
   endfunction

   function automatic logic [7:0] sat8(input logic signed [12:0] v);
      if (v < 13'sd0)
         return 8'd0;
      else if (v > 13'sd255)
         return 8'd255;
      else
         return v[7:0];
   endfunction

   logic [CW-1:0] col, row;
   logic          last_col, last_row, accept;

   assign last_col = (col == CW'(IMG_W - 1));
   assign last_row = (row == CW'(IMG_H - 1));
   assign accept   = bus.in_valid && (col >= CW'(2)) && (row >= CW'(2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (bus.in_valid) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + CW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Stage 1: capture taps and the centre coordinate of the accepted window
   logic          s1_valid, s1_last;
   logic [1:0]    s1_mode;
   logic [CW-1:0] s1_x, s1_y;
   logic [7:0]    s1_tap [9];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_mode  <= 2'd0;
         s1_x     <= '0;
         s1_y     <= '0;
         for (int k = 0; k < 9; k++) s1_tap[k] <= 8'd0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_last   <= last_col && last_row;
            s1_mode   <= bus.mode;
            s1_x      <= col - CW'(1);
            s1_y      <= row - CW'(1);
            s1_tap[0] <= bus.i11;
            s1_tap[1] <= bus.i12;
            s1_tap[2] <= bus.i13;
            s1_tap[3] <= bus.i21;
            s1_tap[4] <= bus.i22;
            s1_tap[5] <= bus.i23;
            s1_tap[6] <= bus.i31;
            s1_tap[7] <= bus.i32;
            s1_tap[8] <= bus.i33;
         end
      end
   end

   logic signed [12:0] corners, edges, centre, sum;

   always_comb begin
      corners = ext(s1_tap[0]) + ext(s1_tap[2]) + ext(s1_tap[6]) + ext(s1_tap[8]);
      edges   = ext(s1_tap[1]) + ext(s1_tap[3]) + ext(s1_tap[5]) + ext(s1_tap[7]);
      centre  = ext(s1_tap[4]);
      sum     = centre;
      case (s1_mode)
         2'd1:    sum = corners + (edges <<< 1) + (centre <<< 2);
         2'd2:    sum = (centre <<< 3) - corners - edges;
         2'd3:    sum = (centre <<< 2) + centre - edges;
         default: sum = centre;
      endcase
   end

   // Stage 2: hold the raw kernel sum; the signed range of every mode fits 13 bits
   logic               s2_valid, s2_last;
   logic [1:0]         s2_mode;
   logic [CW-1:0]      s2_x, s2_y;
   logic signed [12:0] s2_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_mode  <= 2'd0;
         s2_x     <= '0;
         s2_y     <= '0;
         s2_sum   <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_last <= s1_last;
            s2_mode <= s1_mode;
            s2_x    <= s1_x;
            s2_y    <= s1_y;
            s2_sum  <= sum;
         end
      end
   end

   logic signed [12:0] norm;

   always_comb begin
      norm = s2_sum;
      case (s2_mode)
         2'd1:    norm = s2_sum >>> 4;
         2'd2:    norm = (s2_sum < 13'sd0) ? -s2_sum : s2_sum;
         default: norm = s2_sum;
      endcase
   end

   // Stage 3: pixel/coords hold their last value between valid outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.out_pixel  <= 8'd0;
         bus.out_x      <= '0;
         bus.out_y      <= '0;
      end else begin
         bus.out_valid  <= s2_valid;
         bus.frame_done <= s2_valid && s2_last;
         if (s2_valid) begin
            bus.out_pixel <= sat8(norm);
            bus.out_x     <= s2_x;
            bus.out_y     <= s2_y;
         end
      end
   end

endmodule

// File: tb/tb_window_conv3x3.sv
// Directed bench for window_conv3x3 on a 5x4 image: all kernels, saturation,
// latency, bubbles, back-to-back frames, mid-frame reset and mode switching.
`timescale 1ns/1ps
module tb_window_conv3x3;

   localparam int IMG_W = 5;
   localparam int IMG_H = 4;
   localparam int CW    = 8;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);

   typedef struct {
      logic [7:0]    pix;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic          fd;
      int            cyc;
   } rec_t;

   logic clk;
   logic rst;
   window_conv3x3_if #(.CW(CW)) bus ();

   window_conv3x3 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   tests_run;
   int   tests_failed;
   int   cycle;
   int   stray_fd;
   rec_t outq [$];
   int   drive_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Capture every valid output with the cycle it appeared in
   always @(negedge clk) begin
      if (bus.out_valid)
         outq.push_back('{pix: bus.out_pixel, x: bus.out_x, y: bus.out_y,
                          fd: bus.frame_done, cyc: cycle});
      if (bus.frame_done && !bus.out_valid)
         stray_fd <= stray_fd + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic set_taps(input logic [7:0] c, input logic [7:0] n);
      bus.i11 = n; bus.i12 = n; bus.i13 = n;
      bus.i21 = n; bus.i22 = c; bus.i23 = n;
      bus.i31 = n; bus.i32 = n; bus.i33 = n;
   endtask

   // Feeds whole frames; pixels before switch_idx use mode_a, the rest mode_b
   task automatic applyStimulus(input logic [7:0] c, input logic [7:0] n,
                                input logic [1:0] mode_a, input logic [1:0] mode_b,
                                input int switch_idx, input bit gap, input int nframes);
      for (int f = 0; f < nframes; f++) begin
         for (int p = 0; p < NPIX; p++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            set_taps(c, n);
            bus.mode = (p < switch_idx) ? mode_a : mode_b;
            if ((p % IMG_W) >= 2 && (p / IMG_W) >= 2)
               drive_q.push_back(cycle);
            if (gap) begin
               @(posedge clk);
               #1;
               bus.in_valid = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_frames(input string tag, input int nframes,
                               input logic [7:0] pix_first, input logic [7:0] pix_rest);
      int n;
      checkOutput({tag, "_count"}, outq.size(), nframes * NOUT);
      n = (outq.size() < nframes * NOUT) ? outq.size() : nframes * NOUT;
      for (int k = 0; k < n; k++) begin
         int j;
         j = k % NOUT;
         checkOutput($sformatf("%s_pix%0d", tag, k), outq[k].pix,
                     (j == 0) ? pix_first : pix_rest);
         checkOutput($sformatf("%s_x%0d", tag, k), outq[k].x, 1 + j % (IMG_W - 2));
         checkOutput($sformatf("%s_y%0d", tag, k), outq[k].y, 1 + j / (IMG_W - 2));
         checkOutput($sformatf("%s_fd%0d", tag, k), outq[k].fd, (j == NOUT - 1) ? 1 : 0);
         if (k < drive_q.size())
            checkOutput($sformatf("%s_lat%0d", tag, k), outq[k].cyc - drive_q[k], 3);
      end
      outq.delete();
      drive_q.delete();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      stray_fd     = 0;
      cycle        = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.mode     = 2'd0;
      set_taps(8'd0, 8'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_valid", bus.out_valid, 0);
      checkOutput("reset_pixel", bus.out_pixel, 0);
      checkOutput("reset_x", bus.out_x, 0);
      checkOutput("reset_y", bus.out_y, 0);
      checkOutput("reset_fd", bus.frame_done, 0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(8'd100, 8'd100, 2'd0, 2'd0, 0, 1'b0, 1);
      check_frames("pass", 1, 8'd100, 8'd100);
      applyStimulus(8'd100, 8'd100, 2'd1, 2'd1, 0, 1'b0, 1);
      check_frames("gauss", 1, 8'd100, 8'd100);
      applyStimulus(8'd100, 8'd100, 2'd2, 2'd2, 0, 1'b0, 1);
      check_frames("lapl", 1, 8'd0, 8'd0);
      applyStimulus(8'd100, 8'd100, 2'd3, 2'd3, 0, 1'b0, 1);
      check_frames("sharp", 1, 8'd100, 8'd100);

      applyStimulus(8'd50, 8'd50, 2'd3, 2'd3, 0, 1'b0, 2);
      check_frames("b2b", 2, 8'd50, 8'd50);

      applyStimulus(8'd255, 8'd0, 2'd1, 2'd1, 0, 1'b1, 1);
      check_frames("gap_gauss_peak", 1, 8'd63, 8'd63);
      applyStimulus(8'd255, 8'd0, 2'd2, 2'd2, 0, 1'b0, 1);
      check_frames("lapl_peak", 1, 8'd255, 8'd255);
      applyStimulus(8'd255, 8'd0, 2'd3, 2'd3, 0, 1'b0, 1);
      check_frames("sharp_peak", 1, 8'd255, 8'd255);
      applyStimulus(8'd0, 8'd255, 2'd3, 2'd3, 0, 1'b0, 1);
      check_frames("sharp_pit", 1, 8'd0, 8'd0);
      applyStimulus(8'd0, 8'd255, 2'd2, 2'd2, 0, 1'b0, 1);
      check_frames("lapl_pit", 1, 8'd255, 8'd255);
      applyStimulus(8'd0, 8'd255, 2'd1, 2'd1, 0, 1'b0, 1);
      check_frames("gauss_pit", 1, 8'd191, 8'd191);

      applyStimulus(8'd255, 8'd0, 2'd1, 2'd2, 13, 1'b0, 1);
      check_frames("mode_switch", 1, 8'd63, 8'd255);

      // Two windows (pixels 12 and 13) are in flight when reset hits
      for (int p = 0; p < 14; p++) begin
         @(posedge clk);
         #1;
         bus.in_valid = 1'b1;
         bus.mode     = 2'd0;
         set_taps(8'd100, 8'd100);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_valid", bus.out_valid, 0);
      checkOutput("midrst_pixel", bus.out_pixel, 0);
      checkOutput("midrst_x", bus.out_x, 0);
      checkOutput("midrst_y", bus.out_y, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      outq.delete();
      drive_q.delete();
      repeat (6) @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_no_valid", outq.size(), 0);
      applyStimulus(8'd100, 8'd100, 2'd0, 2'd0, 0, 1'b0, 1);
      check_frames("after_rst", 1, 8'd100, 8'd100);

      checkOutput("stray_frame_done", stray_fd, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
